// File: rtl/multi_debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared constants for the multi-channel push-button debouncer:
//   - default values for every multi_debounce parameter
//   - cnt_width(): bit width needed for a counter that must hold 0..limit
// No ports (package).
// -----------------------------------------------------------------------------
package debounce_pkg;

   localparam int DEF_N_CH         = 4;
   localparam int DEF_TICK_DIV     = 50000;  // 1 ms at 50 MHz
   localparam int DEF_STABLE_TICKS = 10;
   localparam int DEF_LONG_TICKS   = 1000;   // 0 disables long-press
   localparam bit DEF_ACTIVE_LOW   = 1'b0;

   // Bits needed to represent every value 0..limit; never less than one bit,
   // so a limit of 0 still yields a legal one-bit counter.
   function automatic int cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/multi_debounce_if.sv
// -----------------------------------------------------------------------------
// multi_debounce_if
// Bundles the button inputs and the debounced outputs of multi_debounce.
//   pb_in      [N_CH] raw button inputs          (master drives)
//   pb_level   [N_CH] debounced pressed state    (slave drives)
//   pb_press   [N_CH] one-cycle press pulses     (slave drives)
//   pb_release [N_CH] one-cycle release pulses   (slave drives)
//   pb_long    [N_CH] one-cycle long-press pulse (slave drives)
// master: the button side / environment; slave: the debouncer.
// -----------------------------------------------------------------------------
interface multi_debounce_if
   import debounce_pkg::*;
#(
   parameter int N_CH = DEF_N_CH
) ();

   logic [N_CH-1:0] pb_in;
   logic [N_CH-1:0] pb_level;
   logic [N_CH-1:0] pb_press;
   logic [N_CH-1:0] pb_release;
   logic [N_CH-1:0] pb_long;

   modport master (
      output pb_in,
      input  pb_level, pb_press, pb_release, pb_long
   );

   modport slave (
      input  pb_in,
      output pb_level, pb_press, pb_release, pb_long
   );

endinterface

// File: rtl/multi_debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One push-button channel: 2-flop synchronizer, stable-level qualifier,
// hold timer and registered press/release/long-press pulses.
//   src_clk    in  clock
//   rst        in  synchronous active-high reset
//   tick_i     in  shared sample tick (one cycle wide)
//   raw_i      in  raw asynchronous button input
//   level_o    out debounced pressed state
//   press_o    out one-cycle pulse when level_o first reads 1
//   release_o  out one-cycle pulse when level_o first reads 0
//   long_o     out one-cycle pulse once per press after LONG_TICKS held
// -----------------------------------------------------------------------------
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_TICKS = DEF_STABLE_TICKS,
   parameter int LONG_TICKS   = DEF_LONG_TICKS,
   parameter bit ACTIVE_LOW   = DEF_ACTIVE_LOW
) (
   input  logic src_clk,
   input  logic rst,
   input  logic tick_i,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o
);

   localparam int STABLE_W = cnt_width(STABLE_TICKS);
   localparam int HOLD_W   = cnt_width(LONG_TICKS);
   localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_TICKS - 1);
   // With LONG_TICKS = 0 the limit is 0, the hold counter can never leave 0
   // and no long-press pulse is ever produced.
   localparam logic [HOLD_W-1:0]   HOLD_LIMIT  = HOLD_W'(LONG_TICKS);

   logic                sync1_q, sync_q;
   logic                level_q, level_d;
   logic [STABLE_W-1:0] stable_q, stable_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                press_q, press_d;
   logic                release_q, release_d;
   logic                long_q, long_d;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      level_d  = level_q;
      stable_d = stable_q;
      hold_d   = hold_q;
      long_d   = 1'b0;

      // Stable qualifier: any agreement with the current level restarts the
      // count immediately; a disagreement only advances on ticks.
      if (sync_q == level_q) begin
         stable_d = '0;
      end else if (tick_i) begin
         if (stable_q == STABLE_LAST) begin
            level_d  = sync_q;
            stable_d = '0;
         end else begin
            stable_d = stable_q + 1'b1;
         end
      end

      press_d   =  level_d & ~level_q;
      release_d = ~level_d &  level_q;

      // Hold timer restarts on every level change and saturates at the limit,
      // which is what limits long_o to one pulse per press.
      if (level_d != level_q) begin
         hold_d = '0;
      end else if (level_q && tick_i && (hold_q != HOLD_LIMIT)) begin
         hold_d = hold_q + 1'b1;
         long_d = (hold_d == HOLD_LIMIT);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before this clock edge.
   always_ff @(posedge src_clk) begin
      if (rst) begin
         sync1_q   <= 1'b0;
         sync_q    <= 1'b0;
         level_q   <= 1'b0;
         stable_q  <= '0;
         hold_q    <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
      end else begin
         // Inversion sits ahead of the first flop so everything downstream
         // sees "pressed" as 1.
         sync1_q   <= raw_i ^ ACTIVE_LOW;
         sync_q    <= sync1_q;
         level_q   <= level_d;
         stable_q  <= stable_d;
         hold_q    <= hold_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign long_o    = long_q;

endmodule

// File: rtl/multi_debounce.sv
// -----------------------------------------------------------------------------
// multi_debounce
// N_CH independent push-button debouncers sharing one sample-tick divider.
//   src_clk    in  clock
//   rst        in  synchronous active-high reset
//   pb_in      in  [N_CH] raw asynchronous button inputs
//   pb_level   out [N_CH] debounced pressed state
//   pb_press   out [N_CH] one-cycle pulse on each accepted press
//   pb_release out [N_CH] one-cycle pulse on each accepted release
//   pb_long    out [N_CH] one-cycle pulse once per press after LONG_TICKS held
// -----------------------------------------------------------------------------
module multi_debounce
   import debounce_pkg::*;
#(
   parameter int N_CH         = DEF_N_CH,
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int STABLE_TICKS = DEF_STABLE_TICKS,
   parameter int LONG_TICKS   = DEF_LONG_TICKS,
   parameter bit ACTIVE_LOW   = DEF_ACTIVE_LOW
) (
   input  logic            src_clk,
   input  logic            rst,
   input  logic [N_CH-1:0] pb_in,
   output logic [N_CH-1:0] pb_level,
   output logic [N_CH-1:0] pb_press,
   output logic [N_CH-1:0] pb_release,
   output logic [N_CH-1:0] pb_long
);

   localparam int TICK_W = cnt_width(TICK_DIV - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic              tick;

   // With TICK_DIV = 1 the counter sits at 0 == TICK_LAST, so tick is
   // permanently high.
   assign tick = (tick_cnt_q == TICK_LAST);

   always_comb begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
   end

   always_ff @(posedge src_clk) begin
      if (rst) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      debounce_channel #(
         .STABLE_TICKS (STABLE_TICKS),
         .LONG_TICKS   (LONG_TICKS),
         .ACTIVE_LOW   (ACTIVE_LOW)
      ) u_ch (
         .src_clk   (src_clk),
         .rst       (rst),
         .tick_i    (tick),
         .raw_i     (pb_in[g]),
         .level_o   (pb_level[g]),
         .press_o   (pb_press[g]),
         .release_o (pb_release[g]),
         .long_o    (pb_long[g])
      );
   end

endmodule

// File: tb/tb_multi_debounce.sv
// -----------------------------------------------------------------------------
// tb_multi_debounce
// Two debouncers (active-high and active-low) with N_CH=2, TICK_DIV=4,
// STABLE_TICKS=3, LONG_TICKS=5. Each scenario task pushes the pulses it
// expects (kind, channel, cycle window) into a queue; a negedge monitor
// records every pulse the DUTs emit, and the task pops both queues and
// compares them.
// -----------------------------------------------------------------------------
module tb_multi_debounce;

   localparam int N_CH         = 2;
   localparam int TICK_DIV     = 4;
   localparam int STABLE_TICKS = 3;
   localparam int LONG_TICKS   = 5;
   localparam int LAT_MIN      = 2 + (STABLE_TICKS - 1) * TICK_DIV + 1;  // 11
   localparam int LAT_MAX      = 2 + STABLE_TICKS * TICK_DIV;            // 14
   localparam int LONG_DLY     = LONG_TICKS * TICK_DIV;                  // 20

   localparam int K_PRESS = 0;
   localparam int K_REL   = 1;
   localparam int K_LONG  = 2;

   typedef struct {
      int kind;
      int ch;
      int lo;
      int hi;
   } exp_t;

   typedef struct {
      int kind;
      int ch;
      int cyc;
   } obs_t;

   logic src_clk = 1'b0;
   logic rst     = 1'b1;
   int   cyc     = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   press_cyc = 0;

   exp_t exp_q[$];
   exp_t exp_b_q[$];
   obs_t obs_q[$];
   obs_t obs_b_q[$];

   multi_debounce_if #(.N_CH(N_CH)) bus ();
   multi_debounce_if #(.N_CH(N_CH)) bus_b ();

   multi_debounce #(
      .N_CH(N_CH), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS(LONG_TICKS), .ACTIVE_LOW(1'b0)
   ) u_dut (
      .src_clk    (src_clk),
      .rst        (rst),
      .pb_in      (bus.pb_in),
      .pb_level   (bus.pb_level),
      .pb_press   (bus.pb_press),
      .pb_release (bus.pb_release),
      .pb_long    (bus.pb_long)
   );

   multi_debounce #(
      .N_CH(N_CH), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS(LONG_TICKS), .ACTIVE_LOW(1'b1)
   ) u_dut_b (
      .src_clk    (src_clk),
      .rst        (rst),
      .pb_in      (bus_b.pb_in),
      .pb_level   (bus_b.pb_level),
      .pb_press   (bus_b.pb_press),
      .pb_release (bus_b.pb_release),
      .pb_long    (bus_b.pb_long)
   );

   always #5 src_clk = ~src_clk;

   always @(posedge src_clk) cyc <= cyc + 1;

   // Record every pulse, ordered by cycle, then kind, then channel.
   always @(negedge src_clk) begin
      for (int c = 0; c < N_CH; c++)
         if (bus.pb_press[c] === 1'b1) obs_q.push_back(obs_t'{K_PRESS, c, cyc});
      for (int c = 0; c < N_CH; c++)
         if (bus.pb_release[c] === 1'b1) obs_q.push_back(obs_t'{K_REL, c, cyc});
      for (int c = 0; c < N_CH; c++)
         if (bus.pb_long[c] === 1'b1) obs_q.push_back(obs_t'{K_LONG, c, cyc});
      for (int c = 0; c < N_CH; c++)
         if (bus_b.pb_press[c] === 1'b1) obs_b_q.push_back(obs_t'{K_PRESS, c, cyc});
      for (int c = 0; c < N_CH; c++)
         if (bus_b.pb_release[c] === 1'b1) obs_b_q.push_back(obs_t'{K_REL, c, cyc});
      for (int c = 0; c < N_CH; c++)
         if (bus_b.pb_long[c] === 1'b1) obs_b_q.push_back(obs_t'{K_LONG, c, cyc});
   end

   // Advance n clock edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge src_clk);
      #1;
   endtask

   task automatic test_reset();
      step(3);
      n_checks++;
      if (bus.pb_level !== 2'b00 || bus.pb_press !== 2'b00 ||
          bus.pb_release !== 2'b00 || bus.pb_long !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_outputs: got lvl=%b prs=%b rel=%b lng=%b, expected all 00",
                  bus.pb_level, bus.pb_press, bus.pb_release, bus.pb_long);
      end
      n_checks++;
      if (bus_b.pb_level !== 2'b00 || bus_b.pb_press !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_outputs_b: got lvl=%b prs=%b, expected 00 00",
                  bus_b.pb_level, bus_b.pb_press);
      end
      rst = 1'b0;
      step(1);
      n_checks++;
      if (obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL reset_quiet: got %0d pulses, expected 0", obs_q.size());
      end
   endtask

   task automatic test_press();
      int   t0;
      exp_t e;
      obs_t o;
      t0 = cyc;
      press_cyc = t0 + LAT_MAX;
      bus.pb_in[0] = 1'b1;
      exp_q.push_back(exp_t'{K_PRESS, 0, t0 + LAT_MIN, t0 + LAT_MAX});
      step(LAT_MAX + 2);
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL press_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (o.kind == K_PRESS && o.ch == 0) press_cyc = o.cyc;
         n_checks++;
         if (o.kind != e.kind || o.ch != e.ch || o.cyc < e.lo || o.cyc > e.hi) begin
            n_fail++;
            $display("FAIL press_event: got kind=%0d ch=%0d cyc=%0d, expected kind=%0d ch=%0d cyc %0d..%0d",
                     o.kind, o.ch, o.cyc, e.kind, e.ch, e.lo, e.hi);
         end
      end
      exp_q.delete();
      obs_q.delete();
      n_checks++;
      if (bus.pb_level !== 2'b01) begin
         n_fail++;
         $display("FAIL press_level: got %b, expected 01", bus.pb_level);
      end
   endtask

   task automatic test_long_release();
      int   t0;
      exp_t e;
      obs_t o;
      exp_q.push_back(exp_t'{K_LONG, 0, press_cyc + LONG_DLY, press_cyc + LONG_DLY});
      step(press_cyc + 40 - cyc);
      t0 = cyc;
      bus.pb_in[0] = 1'b0;
      exp_q.push_back(exp_t'{K_REL, 0, t0 + LAT_MIN, t0 + LAT_MAX});
      step(LAT_MAX + 10);
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL long_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o.kind != e.kind || o.ch != e.ch || o.cyc < e.lo || o.cyc > e.hi) begin
            n_fail++;
            $display("FAIL long_event: got kind=%0d ch=%0d cyc=%0d, expected kind=%0d ch=%0d cyc %0d..%0d",
                     o.kind, o.ch, o.cyc, e.kind, e.ch, e.lo, e.hi);
         end
      end
      exp_q.delete();
      obs_q.delete();
      n_checks++;
      if (bus.pb_level !== 2'b00) begin
         n_fail++;
         $display("FAIL release_level: got %b, expected 00", bus.pb_level);
      end
   endtask

   task automatic test_glitch();
      bus.pb_in[1] = 1'b1;
      step(6);
      bus.pb_in[1] = 1'b0;
      step(30);
      n_checks++;
      if (obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL glitch_pulses: got %0d pulses, expected 0", obs_q.size());
      end
      obs_q.delete();
      n_checks++;
      if (bus.pb_level !== 2'b00) begin
         n_fail++;
         $display("FAIL glitch_level: got %b, expected 00", bus.pb_level);
      end
   endtask

   task automatic test_simultaneous();
      int   t0, t1, p0, p1;
      exp_t e;
      obs_t o;
      p0 = -1;
      p1 = -2;
      t0 = cyc;
      bus.pb_in = 2'b11;
      exp_q.push_back(exp_t'{K_PRESS, 0, t0 + LAT_MIN, t0 + LAT_MAX});
      exp_q.push_back(exp_t'{K_PRESS, 1, t0 + LAT_MIN, t0 + LAT_MAX});
      step(LAT_MAX);
      t1 = cyc;
      bus.pb_in = 2'b00;
      exp_q.push_back(exp_t'{K_REL, 0, t1 + LAT_MIN, t1 + LAT_MAX});
      exp_q.push_back(exp_t'{K_REL, 1, t1 + LAT_MIN, t1 + LAT_MAX});
      step(LAT_MAX + 6);
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL simul_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (o.kind == K_PRESS && o.ch == 0) p0 = o.cyc;
         if (o.kind == K_PRESS && o.ch == 1) p1 = o.cyc;
         n_checks++;
         if (o.kind != e.kind || o.ch != e.ch || o.cyc < e.lo || o.cyc > e.hi) begin
            n_fail++;
            $display("FAIL simul_event: got kind=%0d ch=%0d cyc=%0d, expected kind=%0d ch=%0d cyc %0d..%0d",
                     o.kind, o.ch, o.cyc, e.kind, e.ch, e.lo, e.hi);
         end
      end
      exp_q.delete();
      obs_q.delete();
      n_checks++;
      if (p0 != p1) begin
         n_fail++;
         $display("FAIL simul_same_cycle: got press cycles %0d and %0d, expected equal", p0, p1);
      end
   endtask

   task automatic test_reset_mid();
      int   t0, r, t1;
      exp_t e;
      obs_t o;
      t0 = cyc;
      bus.pb_in[0] = 1'b1;
      exp_q.push_back(exp_t'{K_PRESS, 0, t0 + LAT_MIN, t0 + LAT_MAX});
      step(LAT_MAX + 2);
      n_checks++;
      if (bus.pb_level !== 2'b01) begin
         n_fail++;
         $display("FAIL rstmid_pre_level: got %b, expected 01", bus.pb_level);
      end
      rst = 1'b1;
      step(1);
      r = cyc;
      rst = 1'b0;
      n_checks++;
      if (bus.pb_level !== 2'b00 || bus.pb_press !== 2'b00 ||
          bus.pb_release !== 2'b00 || bus.pb_long !== 2'b00) begin
         n_fail++;
         $display("FAIL rstmid_outputs: got lvl=%b prs=%b rel=%b lng=%b, expected all 00",
                  bus.pb_level, bus.pb_press, bus.pb_release, bus.pb_long);
      end
      exp_q.push_back(exp_t'{K_PRESS, 0, r + LAT_MIN, r + LAT_MAX});
      step(LAT_MAX + 1);
      t1 = cyc;
      bus.pb_in[0] = 1'b0;
      exp_q.push_back(exp_t'{K_REL, 0, t1 + LAT_MIN, t1 + LAT_MAX});
      step(LAT_MAX + 4);
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL rstmid_count: got %0d pulses, expected %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o.kind != e.kind || o.ch != e.ch || o.cyc < e.lo || o.cyc > e.hi) begin
            n_fail++;
            $display("FAIL rstmid_event: got kind=%0d ch=%0d cyc=%0d, expected kind=%0d ch=%0d cyc %0d..%0d",
                     o.kind, o.ch, o.cyc, e.kind, e.ch, e.lo, e.hi);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic test_active_low();
      int   t0;
      exp_t e;
      obs_t o;
      step(10);
      // Nothing may have pulsed on the active-low instance during the whole run.
      n_checks++;
      if (obs_b_q.size() != 0 || bus_b.pb_level !== 2'b00) begin
         n_fail++;
         $display("FAIL actlow_idle: got %0d pulses lvl=%b, expected 0 pulses lvl=00",
                  obs_b_q.size(), bus_b.pb_level);
      end
      obs_b_q.delete();
      t0 = cyc;
      bus_b.pb_in[0] = 1'b0;
      exp_b_q.push_back(exp_t'{K_PRESS, 0, t0 + LAT_MIN, t0 + LAT_MAX});
      step(LAT_MAX + 2);
      n_checks++;
      if (obs_b_q.size() != exp_b_q.size()) begin
         n_fail++;
         $display("FAIL actlow_count: got %0d pulses, expected %0d", obs_b_q.size(), exp_b_q.size());
      end
      while (exp_b_q.size() > 0 && obs_b_q.size() > 0) begin
         e = exp_b_q.pop_front();
         o = obs_b_q.pop_front();
         n_checks++;
         if (o.kind != e.kind || o.ch != e.ch || o.cyc < e.lo || o.cyc > e.hi) begin
            n_fail++;
            $display("FAIL actlow_event: got kind=%0d ch=%0d cyc=%0d, expected kind=%0d ch=%0d cyc %0d..%0d",
                     o.kind, o.ch, o.cyc, e.kind, e.ch, e.lo, e.hi);
         end
      end
      exp_b_q.delete();
      obs_b_q.delete();
      n_checks++;
      if (bus_b.pb_level !== 2'b01) begin
         n_fail++;
         $display("FAIL actlow_level: got %b, expected 01", bus_b.pb_level);
      end
   endtask

   initial begin
      bus.pb_in   = 2'b00;
      bus_b.pb_in = 2'b11;
      test_reset();
      test_press();
      test_long_release();
      test_glitch();
      test_simultaneous();
      test_reset_mid();
      test_active_low();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
